node_weight_gen: RTL and testbench
==================================

NODE_WEIGHT_GEN -- requirements
Module: node_weight_gen

Interface
REQ-001 SHALL have parameter N, default 64, meaning graph node count.
REQ-002 SHALL have parameter WIDTH, default 16, meaning bits per weight (unsigned Q0.WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to compute all weights.
REQ-006 SHALL have port adj, input, N*N, adjacency matrix; row i = adj[i*N +: N], bit j set = edge i->j.
REQ-007 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when every weight is written.
REQ-009 SHALL have port nodeWeight, output, N*WIDTH, slice i = weight of node i, in the layout pageRank consumes.
REQ-010 SHALL have port dangling, output, N, bit i set when node i has out-degree 0.

Function
REQ-011 SHALL define weight(i) as floor(2^WIDTH / deg(i)), where deg(i) = popcount(row i) and deg(i) is (clog2(N+1)) bits wide.
REQ-012 SHALL saturate to all-ones (0xFFFF) when deg = 1, and SHALL output 0 with dangling[i] = 1 when deg = 0.
REQ-013 SHALL use the FSM IDLE -> COUNT -> DIV -> WRITE -> (COUNT | DONE) -> IDLE.
REQ-014 IDLE: start = 1 SHALL snapshot adj into an internal register, clear idx to 0, and go to COUNT; adj changes after that edge SHALL have no effect on the run.
REQ-015 COUNT: one cycle; SHALL register the popcount of snapshot row idx.
REQ-016 DIV: exactly WIDTH+1 cycles of restoring division of 2^WIDTH by deg, every time, including deg 0 and deg 1 (fixed latency).
REQ-017 WRITE: one cycle; SHALL update nodeWeight slice idx and dangling[idx] (applying REQ-012), then go to DONE if idx = N-1, else increment idx and go to COUNT.
REQ-018 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-019 Latency: per node WIDTH+3 cycles; done SHALL assert exactly N*(WIDTH+3)+1 cycles after the start-sampling edge (1217 for default N and WIDTH).
REQ-020 busy SHALL be high from the cycle after start is sampled through the DONE cycle inclusive.
REQ-021 start while not in IDLE SHALL be ignored.
REQ-022 Slices not yet written in the current run SHALL hold their previous values.
REQ-023 Outputs SHALL hold after done until the next accepted start.

Reset
REQ-024 reset SHALL force IDLE, idx = 0, busy = 0, done = 0, nodeWeight = 0, dangling = 0 and the divider registers to 0.
REQ-025 reset SHALL take precedence over start in the same cycle.
REQ-026 reset mid-run SHALL abort with no done pulse.

Structure
REQ-027 Package pr_pkg SHALL hold N, WIDTH, DEG_W = clog2(N+1), and the FSM state encoding, shared with pageRank.
REQ-028 One sub-module, recip_div, SHALL implement the sequential restoring divider with ports: load, divisor, quotient, and a WIDTH+1 cycle fixed latency.
REQ-029 Popcount SHALL be combinational inside node_weight_gen.

Verification
REQ-030 The bench SHALL cover the 64-node edge set pageRank uses (row 0 = {1,29,63}, row 1 = {0,2}, row 6 = {5,7,50,57}) -> nodeWeight[0] = 0x5555, [1] = 0x8000, [6] = 0x4000, with done at cycle 1217.
REQ-031 The bench SHALL cover row i with a single bit -> 0xFFFF; an all-zero row -> 0x0000 and dangling[i] = 1; a full row (deg 64) -> 0x0400.
REQ-032 The bench SHALL cover start re-pulsed at cycle 300 of a run -> ignored, with done still at cycle 1217 and results unchanged.
REQ-033 The bench SHALL cover adj changed the cycle after start -> results match the snapshotted adj.
REQ-034 The bench SHALL cover reset asserted at cycle 500 -> next cycle busy = 0, nodeWeight = 0, and no done pulse; a following start completes normally.
REQ-035 The bench SHALL cover start and reset high in the same cycle -> remains IDLE with busy = 0.

Source files
------------

// File: rtl/pr_pkg.sv
// Shared sizing and FSM encoding for the pageRank node-weight path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pr_pkg;
    localparam int N     = 64;
    localparam int WIDTH = 16;
    localparam int DEG_W = $clog2(N + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DIV,
        ST_WRITE,
        ST_DONE
    } pr_state_t;
endpackage

// File: rtl/recip_div.sv
// Restoring divider computing 2^WIDTH / divisor, one quotient bit per cycle.
// Latency: quotient final WIDTH+1 cycles after the load edge, for every divisor.
// Backpressure: none; a new load restarts the division at any time.
module recip_div #(
    parameter int WIDTH = pr_pkg::WIDTH,
    parameter int DEG_W = pr_pkg::DEG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DEG_W-1:0] divisor,
    output logic [WIDTH:0]   quotient
);
    import pr_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 2);

    logic [DEG_W-1:0] dvs;
    logic [DEG_W-1:0] rem;
    logic [WIDTH:0]   dvd;
    logic [CNT_W-1:0] cnt;
    logic [DEG_W:0]   rem_sh;
    logic [DEG_W:0]   diff;
    logic             fits;

    // A zero divisor always "fits", so the quotient runs to all-ones; the caller masks it.
    assign rem_sh = {rem, dvd[WIDTH]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign fits   = rem_sh >= {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            dvs      <= '0;
            rem      <= '0;
            dvd      <= '0;
            cnt      <= '0;
            quotient <= '0;
        end else if (load) begin
            dvs      <= divisor;
            rem      <= '0;
            dvd      <= {1'b1, {WIDTH{1'b0}}};
            cnt      <= CNT_W'(WIDTH + 1);
            quotient <= '0;
        end else if (cnt != '0) begin
            rem      <= fits ? diff[DEG_W-1:0] : rem_sh[DEG_W-1:0];
            dvd      <= dvd << 1;
            cnt      <= cnt - CNT_W'(1);
            quotient <= {quotient[WIDTH-1:0], fits};
        end
    end
endmodule

// File: rtl/node_weight_gen.sv
// Computes per-node out-edge weights floor(2^WIDTH/deg) from an adjacency snapshot.
// Latency: WIDTH+3 cycles per node; done pulses N*(WIDTH+3)+1 cycles after start.
// Backpressure: start is ignored while busy; outputs hold until the next accepted start.
module node_weight_gen #(
    parameter int N     = pr_pkg::N,
    parameter int WIDTH = pr_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*N-1:0]       adj,
    output logic                 busy,
    output logic                 done,
    output logic [N*WIDTH-1:0]   nodeWeight,
    output logic [N-1:0]         dangling
);
    import pr_pkg::*;

    localparam int DW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    pr_state_t        state;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    dcnt;
    logic [N*N-1:0]   snap;
    logic [DW-1:0]    deg;
    logic [N-1:0]     row;
    logic [DW-1:0]    pop;
    logic [WIDTH:0]   quot;
    logic [WIDTH-1:0] wval;

    always_comb begin
        row = snap[idx*N +: N];
        pop = '0;
        for (int j = 0; j < N; j++) begin
            pop = pop + DW'(row[j]);
        end
    end

    // The divider latches the live popcount in COUNT so DIV starts stepping immediately.
    recip_div #(
        .WIDTH (WIDTH),
        .DEG_W (DW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_COUNT),
        .divisor  (pop),
        .quotient (quot)
    );

    // deg 1 yields 2^WIDTH, one bit too wide, so it saturates.
    always_comb begin
        wval = quot[WIDTH-1:0];
        if (deg == '0) begin
            wval = '0;
        end else if (quot[WIDTH]) begin
            wval = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dcnt       <= '0;
            snap       <= '0;
            deg        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nodeWeight <= '0;
            dangling   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap  <= adj;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    deg   <= pop;
                    dcnt  <= '0;
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    if (dcnt == CW'(WIDTH)) begin
                        state <= ST_WRITE;
                    end else begin
                        dcnt <= dcnt + CW'(1);
                    end
                end
                ST_WRITE: begin
                    nodeWeight[idx*WIDTH +: WIDTH] <= wval;
                    dangling[idx]                  <= (deg == '0);
                    if (idx == IW'(N - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= ST_COUNT;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_node_weight_gen.sv
// Randomized and directed bench for node_weight_gen against a per-row arithmetic model.
module tb_node_weight_gen;
    localparam int N   = 64;
    localparam int W   = 16;
    localparam int LAT = N * (W + 3) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*N-1:0]   adj;
    logic             busy;
    logic             done;
    logic [N*W-1:0]   nodeWeight;
    logic [N-1:0]     dangling;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_w [N];
    logic [N-1:0] exp_d;

    always #5 clk = ~clk;

    node_weight_gen #(.N(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .adj        (adj),
        .busy       (busy),
        .done       (done),
        .nodeWeight (nodeWeight),
        .dangling   (dangling)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [N*N-1:0] a);
        int deg;
        for (int i = 0; i < N; i++) begin
            deg      = $countones(a[i*N +: N]);
            exp_d[i] = (deg == 0);
            if (deg == 0)      exp_w[i] = '0;
            else if (deg == 1) exp_w[i] = '1;
            else               exp_w[i] = W'((1 << W) / deg);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) exp_w[i] = '0;
        exp_d = '0;
    endfunction

    function automatic logic [N*N-1:0] rand_adj();
        logic [N*N-1:0] a;
        logic [N-1:0]   r;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: r = {$urandom, $urandom};
                1: r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2: begin
                    r = '0;
                    r[$urandom_range(0, N - 1)] = 1'b1;
                end
                default: r = '0;
            endcase
            a[i*N +: N] = r;
        end
        return a;
    endfunction

    task automatic check_results(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s w[%0d]", tag, i), 64'(nodeWeight[i*W +: W]), 64'(exp_w[i]));
        end
        check($sformatf("%s dangling", tag), 64'(dangling), 64'(exp_d));
    endtask

    task automatic run(input string tag, input logic [N*N-1:0] a, input bit repulse, input bit chg_adj);
        int           done_cyc;
        int           pulses;
        int           busy_low;
        logic [W-1:0] prev_last;
        done_cyc  = -1;
        pulses    = 0;
        busy_low  = 0;
        prev_last = exp_w[N-1];
        @(negedge clk);
        adj   = a;
        start = 1'b1;
        model(a);
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (chg_adj && c == 1) adj = ~a;
            if (c == 300) begin
                check($sformatf("%s unwritten slice holds", tag), 64'(nodeWeight[(N-1)*W +: W]), 64'(prev_last));
                if (repulse) start = 1'b1;
            end
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c <= LAT && !busy) busy_low++;
            if (c == LAT + 1) check($sformatf("%s busy after done", tag), 64'(busy), 64'd0);
        end
        check($sformatf("%s done cycle", tag), 64'(done_cyc), 64'(LAT));
        check($sformatf("%s done pulses", tag), 64'(pulses), 64'd1);
        check($sformatf("%s busy low cycles", tag), 64'(busy_low), 64'd0);
        check_results(tag);
    endtask

    initial begin
        logic [N*N-1:0] a;
        logic [N-1:0]   r;
        int             pulses;
        int             busy_hi;

        reset = 1'b1;
        start = 1'b0;
        adj   = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset weight nonzero", 64'(|nodeWeight), 64'd0);
        check("reset dangling", 64'(dangling), 64'd0);
        reset = 1'b0;

        a = rand_adj();
        r = '0; r[1] = 1'b1; r[29] = 1'b1; r[63] = 1'b1; a[0*N +: N] = r;
        r = '0; r[0] = 1'b1; r[2] = 1'b1;                a[1*N +: N] = r;
        r = '0; r[40] = 1'b1;                            a[2*N +: N] = r;
        r = '0;                                          a[3*N +: N] = r;
        r = '1;                                          a[4*N +: N] = r;
        r = '0; r[5] = 1'b1; r[7] = 1'b1; r[50] = 1'b1; r[57] = 1'b1; a[6*N +: N] = r;
        run("pagerank", a, 1'b0, 1'b0);
        check("pr w0", 64'(nodeWeight[0*W +: W]), 64'h5555);
        check("pr w1", 64'(nodeWeight[1*W +: W]), 64'h8000);
        check("pr w2 single", 64'(nodeWeight[2*W +: W]), 64'hFFFF);
        check("pr w3 empty", 64'(nodeWeight[3*W +: W]), 64'h0000);
        check("pr dangling3", 64'(dangling[3]), 64'd1);
        check("pr w4 full", 64'(nodeWeight[4*W +: W]), 64'h0400);
        check("pr w6", 64'(nodeWeight[6*W +: W]), 64'h4000);

        run("repulse", rand_adj(), 1'b1, 1'b1);
        run("adjchg", rand_adj(), 1'b0, 1'b1);

        // Abort mid-run: everything clears, no done pulse, nothing restarts on its own.
        @(negedge clk);
        adj   = rand_adj();
        start = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 500) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort weight nonzero", 64'(|nodeWeight), 64'd0);
        check("abort dangling", 64'(dangling), 64'd0);
        model_clear();
        pulses  = 0;
        busy_hi = 0;
        for (int c = 0; c < LAT + 20; c++) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_hi++;
        end
        check("abort done pulses", 64'(pulses), 64'd0);
        check("abort busy cycles", 64'(busy_hi), 64'd0);
        run("after abort", rand_adj(), 1'b0, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        adj   = rand_adj();
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("start+reset busy", 64'(busy), 64'd0);
        model_clear();
        pulses  = 0;
        busy_hi = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_hi++;
        end
        check("start+reset done pulses", 64'(pulses), 64'd0);
        check("start+reset busy cycles", 64'(busy_hi), 64'd0);
        check_results("start+reset");

        run("final", rand_adj(), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
